// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response handshake bundle for alu_exec_unit.
interface alu_exec_unit_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] alu_sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] alu_result;
    logic       carryout;
    logic       busy;

    modport master (
        output in_valid, a, b, alu_sel, out_ready,
        input  in_ready, out_valid, alu_result, carryout, busy
    );

    modport slave (
        input  in_valid, a, b, alu_sel, out_ready,
        output in_ready, out_valid, alu_result, carryout, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: 8-bit ALU with valid/ready handshake, 8-cycle shift-add multiplier.
// Define ALU_DIV_EN to add an 8-cycle restoring divider for opcode 3.
module alu_exec_unit (
    input logic           clk,
    input logic           rst,
    alu_exec_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [7:0]  op_a, op_a_n, op_b, op_b_n, res, res_n;
    logic [15:0] p, p_n;
    logic        cy, cy_n;
    logic        accept, multi;
    logic [8:0]  single, fin;
    logic [15:0] mul_step, step;

    assign bus.in_ready   = state == IDLE || (state == DONE && bus.out_ready);
    assign bus.out_valid  = state == DONE;
    assign bus.busy       = state == BUSY;
    assign bus.alu_result = res;
    assign bus.carryout   = cy;
    assign accept         = bus.in_valid && bus.in_ready;

    // One partial product per cycle: p accumulates a << cnt when b[cnt] is set
    assign mul_step = p + (op_b[cnt] ? ({8'h00, op_a} << cnt) : 16'h0000);

`ifdef ALU_DIV_EN
    logic       is_div, is_div_n, ge;
    logic [8:0] rem_sh;
    logic [15:0] div_step;
    // p holds {remainder, dividend/quotient}; quotient bits shift in from the right
    assign rem_sh   = {p[15:8], p[7]};
    assign ge       = rem_sh >= {1'b0, op_b};
    assign div_step = {ge ? rem_sh[7:0] - op_b : rem_sh[7:0], p[6:0], ge};
    assign step     = is_div ? div_step : mul_step;
    assign fin      = is_div ? {1'b0, step[7:0]} : {|step[15:8], step[7:0]};
    assign multi    = bus.alu_sel == 4'h2 || (bus.alu_sel == 4'h3 && bus.b != 8'h00);
`else
    assign step  = mul_step;
    assign fin   = {|step[15:8], step[7:0]};
    assign multi = bus.alu_sel == 4'h2;
`endif

    always_comb begin
        single = 9'h000;
        case (bus.alu_sel)
            4'h0: single = {1'b0, bus.a} + {1'b0, bus.b};
            4'h1: single = {1'b0, bus.a} - {1'b0, bus.b};
`ifdef ALU_DIV_EN
            4'h3: single = bus.b == 8'h00 ? 9'h1FF : 9'h000;
`endif
            4'h4: single = {bus.a[7], bus.a[6:0], 1'b0};
            4'h5: single = {bus.a[0], 1'b0, bus.a[7:1]};
            4'h6: single = {1'b0, bus.a[6:0], bus.a[7]};
            4'h7: single = {1'b0, bus.a[0], bus.a[7:1]};
            4'h8: single = {1'b0, bus.a & bus.b};
            4'h9: single = {1'b0, bus.a | bus.b};
            4'hA: single = {1'b0, bus.a ^ bus.b};
            4'hB: single = {1'b0, ~(bus.a | bus.b)};
            4'hC: single = {1'b0, ~(bus.a & bus.b)};
            4'hD: single = {1'b0, ~(bus.a ^ bus.b)};
            4'hE: single = {8'h00, bus.a > bus.b};
            4'hF: single = {8'h00, bus.a == bus.b};
            default: single = 9'h000;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_a_n  = op_a;
        op_b_n  = op_b;
        p_n     = p;
        res_n   = res;
        cy_n    = cy;
`ifdef ALU_DIV_EN
        is_div_n = is_div;
`endif
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    op_a_n = bus.a;
                    op_b_n = bus.b;
                    if (multi) begin
                        state_n = BUSY;
                        cnt_n   = 3'd0;
                        p_n     = 16'h0000;
`ifdef ALU_DIV_EN
                        is_div_n = bus.alu_sel == 4'h3;
                        p_n      = bus.alu_sel == 4'h3 ? {8'h00, bus.a} : 16'h0000;
`endif
                    end else begin
                        state_n       = DONE;
                        {cy_n, res_n} = single;
                    end
                end else if (state == DONE && bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            BUSY: begin
                p_n   = step;
                cnt_n = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    state_n       = DONE;
                    {cy_n, res_n} = fin;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            op_a  <= 8'h00;
            op_b  <= 8'h00;
            p     <= 16'h0000;
            res   <= 8'h00;
            cy    <= 1'b0;
`ifdef ALU_DIV_EN
            is_div <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_a  <= op_a_n;
            op_b  <= op_b_n;
            p     <= p_n;
            res   <= res_n;
            cy    <= cy_n;
`ifdef ALU_DIV_EN
            is_div <= is_div_n;
`endif
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed-vector bench for alu_exec_unit (honours ALU_DIV_EN).
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_exec_unit_if bus();
    alu_exec_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // Issue one request from IDLE, scramble inputs after acceptance, wait for out_valid
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] is,
                          output int lat, output int bcnt, output bit rdy_bad,
                          output logic [7:0] r, output logic c);
        @(negedge clk);
        bus.a = ia; bus.b = ib; bus.alu_sel = is; bus.in_valid = 1'b1;
        bcnt = 0; rdy_bad = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.a = ~ia; bus.b = ~ib; bus.alu_sel = is ^ 4'h5;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) bcnt++;
            if (bus.busy === 1'b1 && bus.in_ready !== 1'b0) rdy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        r = bus.alu_result;
        c = bus.carryout;
    endtask

    task automatic retire();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.alu_sel = 4'h0; bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        checks++; if (bus.alu_result !== 8'h00) begin errors++; $display("FAIL rst_result got %h want 00", bus.alu_result); end
        checks++; if (bus.carryout !== 1'b0) begin errors++; $display("FAIL rst_carry got %b want 0", bus.carryout); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat, bcnt; bit rb; logic [7:0] r; logic c;
        run_op(8'h0A, 8'h02, 4'h0, lat, bcnt, rb, r, c);
        checks++; if (lat != 1) begin errors++; $display("FAIL add1_latency got %0d want 1", lat); end
        checks++; if (r !== 8'h0C || c !== 1'b0) begin errors++; $display("FAIL add1_result got %h/%b want 0c/0", r, c); end
        retire();
        run_op(8'hF2, 8'hD3, 4'h0, lat, bcnt, rb, r, c);
        checks++; if (lat != 1) begin errors++; $display("FAIL add2_latency got %0d want 1", lat); end
        checks++; if (r !== 8'hC5 || c !== 1'b1) begin errors++; $display("FAIL add2_result got %h/%b want c5/1", r, c); end
        retire();
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        bus.a = 8'hF2; bus.b = 8'hD3; bus.alu_sel = 4'h2; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstbusy_pre_busy got %b want 1", bus.busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstbusy_busy got %b want 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstbusy_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstbusy_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.alu_result !== 8'h00 || bus.carryout !== 1'b0) begin errors++; $display("FAIL rstbusy_result got %h/%b want 00/0", bus.alu_result, bus.carryout); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstbusy_after_%0d valid/ready got %b/%b want 0/1", i, bus.out_valid, bus.in_ready); end
        end
    endtask

    task automatic test_mul();
        int lat, bcnt; bit rb; logic [7:0] r; logic c;
        run_op(8'hF2, 8'hD3, 4'h2, lat, bcnt, rb, r, c);
        checks++; if (bcnt != 8) begin errors++; $display("FAIL mul_busy_cycles got %0d want 8", bcnt); end
        checks++; if (rb) begin errors++; $display("FAIL mul_in_ready_in_busy got 1 want 0"); end
        checks++; if (lat != 9) begin errors++; $display("FAIL mul_latency got %0d want 9", lat); end
        checks++; if (r !== 8'h76 || c !== 1'b1) begin errors++; $display("FAIL mul_result got %h/%b want 76/1", r, c); end
        retire();
    endtask

    task automatic test_hold();
        int lat, bcnt; bit rb; logic [7:0] r; logic c;
        run_op(8'h02, 8'h0A, 4'h1, lat, bcnt, rb, r, c);
        checks++; if (lat != 1 || r !== 8'hF8 || c !== 1'b1) begin errors++; $display("FAIL sub_result got %0d/%h/%b want 1/f8/1", lat, r, c); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1 || bus.alu_result !== 8'hF8 || bus.carryout !== 1'b1) begin errors++; $display("FAIL hold_%0d got %b/%h/%b want 1/f8/1", i, bus.out_valid, bus.alu_result, bus.carryout); end
        end
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.a = 8'hF0; bus.b = 8'h3C; bus.alu_sel = 4'h8;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_result !== 8'h30 || bus.carryout !== 1'b0) begin errors++; $display("FAIL b2b_result got %b/%h/%b want 1/30/0", bus.out_valid, bus.alu_result, bus.carryout); end
        retire();
    endtask

    task automatic test_div();
        int lat, bcnt; bit rb; logic [7:0] r; logic c;
`ifdef ALU_DIV_EN
        run_op(8'h0A, 8'h02, 4'h3, lat, bcnt, rb, r, c);
        checks++; if (lat != 9 || r !== 8'h05 || c !== 1'b0) begin errors++; $display("FAIL div_result got %0d/%h/%b want 9/05/0", lat, r, c); end
        retire();
        run_op(8'h0A, 8'h00, 4'h3, lat, bcnt, rb, r, c);
        checks++; if (lat != 1 || r !== 8'hFF || c !== 1'b1) begin errors++; $display("FAIL div0_result got %0d/%h/%b want 1/ff/1", lat, r, c); end
        retire();
        run_op(8'hFF, 8'h10, 4'h3, lat, bcnt, rb, r, c);
        checks++; if (lat != 9 || r !== 8'h0F || c !== 1'b0) begin errors++; $display("FAIL div2_result got %0d/%h/%b want 9/0f/0", lat, r, c); end
        retire();
`else
        run_op(8'h0A, 8'h02, 4'h3, lat, bcnt, rb, r, c);
        checks++; if (lat != 1 || r !== 8'h00 || c !== 1'b0) begin errors++; $display("FAIL div_off_result got %0d/%h/%b want 1/00/0", lat, r, c); end
        retire();
`endif
    endtask

    task automatic test_boundary();
        logic [7:0] ta [11] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h55, 8'h55, 8'h56, 8'h00, 8'hFF, 8'h10, 8'hFF};
        logic [7:0] tb [11] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h56, 8'h55, 8'h01, 8'h01, 8'h10, 8'hFF};
        logic [3:0] ts [11] = '{4'h4, 4'h5, 4'h6, 4'h7, 4'hF, 4'hE, 4'hE, 4'h1, 4'h0, 4'h2, 4'hB};
        logic [7:0] tr [11] = '{8'h02, 8'h40, 8'h03, 8'hC0, 8'h01, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00};
        logic       tc [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int lat, bcnt; bit rb; logic [7:0] r; logic c;
        for (int i = 0; i < 11; i++) begin
            run_op(ta[i], tb[i], ts[i], lat, bcnt, rb, r, c);
            checks++; if (lat != (ts[i] == 4'h2 ? 9 : 1) || r !== tr[i] || c !== tc[i]) begin errors++; $display("FAIL boundary_%0d got %0d/%h/%b want %0d/%h/%b", i, lat, r, c, ts[i] == 4'h2 ? 9 : 1, tr[i], tc[i]); end
            retire();
        end
    endtask

    task automatic test_sweep();
        logic [7:0] er [16] = '{8'h0C, 8'h08, 8'h14, 8'h00, 8'h14, 8'h05, 8'h14, 8'h05,
                                8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
        int el [16] = '{1, 1, 9, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        int lat, bcnt; bit rb; logic [7:0] r; logic c;
`ifdef ALU_DIV_EN
        er[3] = 8'h05;
        el[3] = 9;
`endif
        for (int s = 0; s < 16; s++) begin
            run_op(8'h0A, 8'h02, 4'(s), lat, bcnt, rb, r, c);
            checks++; if (lat != el[s] || r !== er[s] || c !== 1'b0) begin errors++; $display("FAIL sweep_sel%h got %0d/%h/%b want %0d/%h/0", s, lat, r, c, el[s], er[s]); end
            retire();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_reset_busy();
        test_mul();
        test_hold();
        test_div();
        test_boundary();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL use one clock and one asynchronous, active-high reset: clk drives all state; rst clears it immediately, regardless of clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  operation request present on a, b, alu_sel.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 a  input  8  operand A, unsigned.
REQ-007 b  input  8  operand B, unsigned.
REQ-008 alu_sel  input  4  opcode, encoding per REQ-014.
REQ-009 out_valid  output  1  alu_result and carryout hold a completed result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 alu_result  output  8  registered result.
REQ-012 carryout  output  1  registered carry/flag bit.
REQ-013 busy  output  1  high while state is BUSY.

Function
REQ-014 Opcodes SHALL be: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL, 5 SHR, 6 ROL, 7 ROR, 8 AND, 9 OR, A XOR, B NOR, C NAND, D XNOR, E GT, F EQ.
REQ-015 FSM states SHALL be IDLE, BUSY and DONE.
REQ-016 in_ready SHALL be (state==IDLE) or (state==DONE and out_ready).
REQ-017 A request SHALL be accepted on the rising edge where in_valid and in_ready are both high. Operands and opcode are captured at that edge.
REQ-018 Single-cycle ops (all except MUL, enabled DIV): the accepting edge SHALL load the result and enter DONE. out_valid is high the next cycle (latency 1).
REQ-019 MUL and enabled DIV: the accepting edge SHALL enter BUSY with a 3-bit counter of 0. BUSY SHALL run one iteration per cycle for 8 cycles. The edge ending the 8th cycle loads the result and enters DONE (out_valid 9 cycles after acceptance).
REQ-020 Inputs SHALL be ignored in BUSY (in_ready low). Changes to a, b, alu_sel after acceptance SHALL NOT affect the result.
REQ-021 DONE SHALL hold alu_result, carryout and out_valid stable until out_ready is high.
REQ-022 DONE with out_ready high and no accept SHALL go to IDLE.
REQ-023 DONE with out_ready and in_valid both high SHALL accept the new request in the same cycle (back-to-back), per REQ-018/019.
REQ-024 ADD SHALL give result (a+b)[7:0] and carryout bit 8 of the sum.
REQ-025 SUB SHALL give result (a-b)[7:0] and carryout 1 if a<b (borrow).
REQ-026 MUL SHALL use 8-iteration shift-add, giving result as product[7:0] and carryout as OR of product[15:8].
REQ-027 SHL SHALL give result a<<1 with carryout a[7]. SHR SHALL give result a>>1 with carryout a[0].
REQ-028 ROL/ROR SHALL rotate a by 1 with carryout 0.
REQ-029 Logic ops SHALL be bitwise on a,b with carryout 0.
REQ-030 GT SHALL give result 8'h01 if a>b, else 8'h00, with carryout 0. EQ SHALL give result 8'h01 if a==b, else 8'h00, with carryout 0.

Reset
REQ-031 rst SHALL force state IDLE, counter 0, alu_result 8'h00, carryout 0, out_valid 0 and busy 0. in_ready is then 1.
REQ-032 rst asserted in BUSY or DONE SHALL discard the operation. No result SHALL be presented after reset release.

Configuration
REQ-033 Macro ALU_DIV_EN defined: DIV SHALL use 8-iteration restoring division, giving result = quotient a/b and carryout 0, per REQ-019.
REQ-034 DIV with ALU_DIV_EN defined and b==0 SHALL skip BUSY: latency 1, result 8'hFF, carryout 1.
REQ-035 Macro ALU_DIV_EN undefined: DIV SHALL be single-cycle with result 8'h00 and carryout 0. No divider logic SHALL be synthesized.

Verification
REQ-036 a=0A, b=02, sel=0, in_valid pulse -> next cycle out_valid=1, alu_result=0C, carryout=0. Then a=F2, b=D3, sel=0 -> C5, carryout=1.
REQ-037 a=F2, b=D3, sel=2 -> busy high 8 cycles, in_ready low throughout; out_valid 9 cycles after accept with alu_result=76, carryout=1.
REQ-038 out_ready held low 5 cycles with a SUB 02-0A result pending -> alu_result=F8, carryout=1 stable every cycle. Release out_ready together with a new valid AND request -> accepted the same cycle.
REQ-039 ALU_DIV_EN defined: a=0A, b=02, sel=3 -> 05 after 9 cycles. a=0A, b=00, sel=3 -> FF, carryout=1, latency 1. Macro undefined: sel=3 -> 00, latency 1.
REQ-040 rst asserted in BUSY cycle 4 of a MUL -> all outputs reset immediately; after release in_ready=1, out_valid stays 0.
REQ-041 Sweep sel 0..F with a=0A, b=02 -> every result matches REQ-024..030.
